instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 227 ++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch
//   Reads a two-byte reset vector, then fetches variable-length (1..3 byte)
//   instructions from a synchronous-read memory and presents each one with a
//   valid/ready handshake. A redirect request can restart fetch at any
//   address once the vector has been loaded.
//
// Ports
//   clk            sole clock, rising edge
//   resetn         synchronous active-low reset
//   mem_enable     read strobe to memory
//   mem_address    read address (data returns on mem_rd_data next cycle)
//   mem_rd_data    read data
//   instr_valid    a complete instruction is presented
//   instr_ready    downstream accepts the instruction
//   opcode         first instruction byte
//   operand_lo     second byte, zero if not part of the instruction
//   operand_hi     third byte, zero if not part of the instruction
//   instr_length   byte count 1..3
//   instr_pc       address of the opcode byte
//   pc_load_valid  redirect request
//   pc_load_addr   redirect target
//
// state    | meaning
// VEC0     | read vector low byte
// VEC1     | read vector high byte, capture low byte
// VEC2     | capture high byte, load pc
// ISSUE_OP | read opcode at pc
// CAP_OP   | capture opcode, decode length, read pc+1 if needed
// CAP_B1   | capture operand_lo, read pc+2 if needed
// CAP_B2   | capture operand_hi
// DELIVER  | instruction presented, wait for handshake

module instr_fetch #(
  parameter int                DEPTH        = 16,
  parameter int                WIDTH        = 8,
  parameter logic [DEPTH-1:0]  RESET_VECTOR = 16'hFFFC
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             mem_enable,
  output logic [DEPTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] opcode,
  output logic [WIDTH-1:0] operand_lo,
  output logic [WIDTH-1:0] operand_hi,
  output logic [1:0]       instr_length,
  output logic [DEPTH-1:0] instr_pc,
  input  logic             pc_load_valid,
  input  logic [DEPTH-1:0] pc_load_addr
);

  typedef enum logic [2:0] {
    VEC0,
    VEC1,
    VEC2,
    ISSUE_OP,
    CAP_OP,
    CAP_B1,
    CAP_B2,
    DELIVER
  } state_e;

  localparam logic [DEPTH-1:0] ADDR_ONE = DEPTH'(1);
  localparam logic [DEPTH-1:0] ADDR_TWO = DEPTH'(2);

  state_e           state_q, state_d;
  logic [DEPTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] vec_lo_q, vec_lo_d;
  logic [WIDTH-1:0] opcode_q, opcode_d;
  logic [WIDTH-1:0] operand_lo_q, operand_lo_d;
  logic [WIDTH-1:0] operand_hi_q, operand_hi_d;
  logic [1:0]       length_q, length_d;

  logic             rd_en;
  logic [DEPTH-1:0] rd_addr;
  logic             valid;
  logic [1:0]       dec_len;
  logic [DEPTH-1:0] len_ext;

  // Length decode works on the low 8 bits of the opcode byte.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    if (op == 8'h20 || op[3:2] == 2'b11 || op[4:0] == 5'b11001) begin
      len = 2'd3;
    end else if (op[3:0] == 4'h8 || op[3:0] == 4'hA ||
                 op == 8'h00 || op == 8'h40 || op == 8'h60) begin
      len = 2'd1;
    end else begin
      len = 2'd2;
    end
    return len;
  endfunction

  assign dec_len = decode_len(mem_rd_data[7:0]);
  assign len_ext = {{(DEPTH-2){1'b0}}, length_q};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    vec_lo_d     = vec_lo_q;
    opcode_d     = opcode_q;
    operand_lo_d = operand_lo_q;
    operand_hi_d = operand_hi_q;
    length_d     = length_q;
    rd_en        = 1'b0;
    rd_addr      = pc_q;
    valid        = 1'b0;

    case (state_q)
      VEC0: begin
        rd_addr = RESET_VECTOR;
        rd_en   = 1'b1;
        state_d = VEC1;
      end
      VEC1: begin
        rd_addr  = RESET_VECTOR + ADDR_ONE;
        rd_en    = 1'b1;
        vec_lo_d = mem_rd_data;
        state_d  = VEC2;
      end
      VEC2: begin
        pc_d    = DEPTH'({mem_rd_data, vec_lo_q});
        state_d = ISSUE_OP;
      end
      ISSUE_OP: begin
        // A redirect suppresses the read so nothing stale is left in flight.
        if (pc_load_valid) begin
          pc_d = pc_load_addr;
        end else begin
          rd_en   = 1'b1;
          state_d = CAP_OP;
        end
      end
      CAP_OP: begin
        if (pc_load_valid) begin
          pc_d    = pc_load_addr;
          state_d = ISSUE_OP;
        end else begin
          opcode_d     = mem_rd_data;
          length_d     = dec_len;
          operand_lo_d = '0;
          operand_hi_d = '0;
          if (dec_len == 2'd1) begin
            state_d = DELIVER;
          end else begin
            rd_addr = pc_q + ADDR_ONE;
            rd_en   = 1'b1;
            state_d = CAP_B1;
          end
        end
      end
      CAP_B1: begin
        if (pc_load_valid) begin
          pc_d    = pc_load_addr;
          state_d = ISSUE_OP;
        end else begin
          operand_lo_d = mem_rd_data;
          if (length_q == 2'd3) begin
            rd_addr = pc_q + ADDR_TWO;
            rd_en   = 1'b1;
            state_d = CAP_B2;
          end else begin
            state_d = DELIVER;
          end
        end
      end
      CAP_B2: begin
        if (pc_load_valid) begin
          pc_d    = pc_load_addr;
          state_d = ISSUE_OP;
        end else begin
          operand_hi_d = mem_rd_data;
          state_d      = DELIVER;
        end
      end
      DELIVER: begin
        valid = 1'b1;
        if (instr_ready) begin
          pc_d    = pc_q + len_ext;
          state_d = ISSUE_OP;
        end
        // A coincident redirect still completes the handshake but wins the pc.
        if (pc_load_valid) begin
          pc_d    = pc_load_addr;
          state_d = ISSUE_OP;
        end
      end
      default: begin
        state_d = VEC0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= VEC0;
      pc_q         <= '0;
      vec_lo_q     <= '0;
      opcode_q     <= '0;
      operand_lo_q <= '0;
      operand_hi_q <= '0;
      length_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      vec_lo_q     <= vec_lo_d;
      opcode_q     <= opcode_d;
      operand_lo_q <= operand_lo_d;
      operand_hi_q <= operand_hi_d;
      length_q     <= length_d;
    end
  end

  // The state sits in VEC0 throughout reset; the strobe is held off until
  // resetn is high so the first read is the vector fetch itself.
  assign mem_enable   = rd_en & resetn;
  assign mem_address  = rd_addr;
  assign instr_valid  = valid;
  assign opcode       = opcode_q;
  assign operand_lo   = operand_lo_q;
  assign operand_hi   = operand_hi_q;
  assign instr_length = length_q;
  assign instr_pc     = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_enable;
  logic [15:0] mem_address;
  logic [7:0]  mem_rd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode, operand_lo, operand_hi;
  logic [1:0]  instr_length;
  logic [15:0] instr_pc;
  logic        pc_load_valid;
  logic [15:0] pc_load_addr;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_mis = 0;

  logic        o_valid, o_en;
  logic [15:0] o_addr, o_pc;
  logic [7:0]  o_op, o_lo, o_hi;
  logic [1:0]  o_len;

  instr_fetch dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_enable    (mem_enable),
    .mem_address   (mem_address),
    .mem_rd_data   (mem_rd_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand_lo    (operand_lo),
    .operand_hi    (operand_hi),
    .instr_length  (instr_length),
    .instr_pc      (instr_pc),
    .pc_load_valid (pc_load_valid),
    .pc_load_addr  (pc_load_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (mem_enable) mem_rd_data <= mem[mem_address];
    else            mem_rd_data <= 8'($urandom);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    if (op == 8'h20 || op[3:2] == 2'b11 || op[4:0] == 5'b11001) return 2'd3;
    if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60)
      return 2'd1;
    return 2'd2;
  endfunction

  // Inputs set before the call apply for the whole cycle; outputs are
  // sampled mid-cycle, then the cycle's rising edge is consumed.
  task automatic run_cycle();
    @(negedge clk);
    o_valid = instr_valid;
    o_en    = mem_enable;
    o_addr  = mem_address;
    o_op    = opcode;
    o_lo    = operand_lo;
    o_hi    = operand_hi;
    o_len   = instr_length;
    o_pc    = instr_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    resetn        = 1'b0;
    instr_ready   = 1'b0;
    pc_load_valid = 1'b0;
    run_cycle();
    run_cycle();
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int k;
    k = 0;
    do begin
      run_cycle();
      k++;
    end while (!o_valid && k < max_cyc);
    n_cmp++;
    if (!o_valid) begin
      n_mis++;
      $display("FAIL %s_timeout: instr_valid=0 after %0d cycles, required 1", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    instr_ready   = 1'b1;
    pc_load_valid = 1'b1;
    pc_load_addr  = 16'h1234;
    repeat (3) run_cycle();
    n_cmp++;
    if ({o_valid, o_en} !== 2'b00) begin
      n_mis++;
      $display("FAIL reset_strobes: valid/en=%b required 00", {o_valid, o_en});
    end
    n_cmp++;
    if (o_addr !== 16'hFFFC) begin
      n_mis++;
      $display("FAIL reset_addr: got %h required fffc", o_addr);
    end
    n_cmp++;
    if ({o_op, o_lo, o_hi, o_len, o_pc} !== 42'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: op=%h lo=%h hi=%h len=%0d pc=%h required all 0",
               o_op, o_lo, o_hi, o_len, o_pc);
    end
    pc_load_valid = 1'b0;
    instr_ready   = 1'b0;
  endtask

  task automatic test_first_fetch();
    logic [6:0]  en_pat;
    logic [15:0] addr_tab [5];
    en_pat   = 7'b0011011;
    addr_tab = '{16'hFFFC, 16'hFFFD, 16'h0000, 16'h8000, 16'h8001};
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h8002] = 8'h4C; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
    reset_release();
    for (int c = 0; c < 7; c++) begin
      instr_ready = (c == 6);
      run_cycle();
      n_cmp++;
      if (o_en !== en_pat[c] || o_valid !== (c == 6)) begin
        n_mis++;
        $display("FAIL first_c%0d_strobes: en=%b valid=%b required en=%b valid=%b",
                 c, o_en, o_valid, en_pat[c], (c == 6));
      end
      if (en_pat[c]) begin
        n_cmp++;
        if (o_addr !== addr_tab[c]) begin
          n_mis++;
          $display("FAIL first_c%0d_addr: got %h required %h", c, o_addr, addr_tab[c]);
        end
      end
    end
    n_cmp++;
    if ({o_op, o_lo, o_hi, o_len, o_pc} !== {8'hA9, 8'h42, 8'h00, 2'd2, 16'h8000}) begin
      n_mis++;
      $display("FAIL first_instr: op=%h lo=%h hi=%h len=%0d pc=%h required a9 42 00 2 8000",
               o_op, o_lo, o_hi, o_len, o_pc);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_three_byte();
    run_cycle();
    n_cmp++;
    if (o_en !== 1'b1 || o_addr !== 16'h8002) begin
      n_mis++;
      $display("FAIL tb3_issue: en=%b addr=%h required 1 8002", o_en, o_addr);
    end
    wait_valid("tb3", 12);
    n_cmp++;
    if ({o_op, o_lo, o_hi, o_len, o_pc} !== {8'h4C, 8'h34, 8'h12, 2'd3, 16'h8002}) begin
      n_mis++;
      $display("FAIL tb3_instr: op=%h lo=%h hi=%h len=%0d pc=%h required 4c 34 12 3 8002",
               o_op, o_lo, o_hi, o_len, o_pc);
    end
    instr_ready = 1'b1;
    run_cycle();
    instr_ready = 1'b0;
    run_cycle();
    n_cmp++;
    if (o_en !== 1'b1 || o_addr !== 16'h8005) begin
      n_mis++;
      $display("FAIL tb3_next: en=%b addr=%h required 1 8005", o_en, o_addr);
    end
  endtask

  task automatic test_stall();
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'hEA;
    reset_release();
    wait_valid("stall", 12);
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      n_cmp++;
      if ({o_valid, o_en, o_op, o_lo, o_hi, o_len, o_pc} !==
          {1'b1, 1'b0, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000}) begin
        n_mis++;
        $display("FAIL stall_%0d: v=%b en=%b op=%h lo=%h hi=%h len=%0d pc=%h required 1 0 ea 00 00 1 8000",
                 k, o_valid, o_en, o_op, o_lo, o_hi, o_len, o_pc);
      end
    end
    instr_ready = 1'b1;
    run_cycle();
    instr_ready = 1'b0;
    run_cycle();
    n_cmp++;
    if ({o_valid, o_en, o_addr} !== {1'b0, 1'b1, 16'h8001}) begin
      n_mis++;
      $display("FAIL stall_next: v=%b en=%b addr=%h required 0 1 8001", o_valid, o_en, o_addr);
    end
  endtask

  task automatic test_redirect();
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'h4C; mem[16'h9000] = 8'hEA;
    reset_release();
    for (int c = 0; c < 7; c++) begin
      pc_load_valid = (c == 5);
      pc_load_addr  = (c == 5) ? 16'h9000 : 16'($urandom);
      run_cycle();
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL redir_c%0d_valid: got %b required 0", c, o_valid);
      end
    end
    n_cmp++;
    if (o_en !== 1'b1 || o_addr !== 16'h9000) begin
      n_mis++;
      $display("FAIL redir_issue: en=%b addr=%h required 1 9000", o_en, o_addr);
    end
    wait_valid("redir", 12);
    n_cmp++;
    if ({o_op, o_len, o_pc} !== {8'hEA, 2'd1, 16'h9000}) begin
      n_mis++;
      $display("FAIL redir_instr: op=%h len=%0d pc=%h required ea 1 9000", o_op, o_len, o_pc);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFF] = 8'hAD; mem[16'h0000] = 8'h10; mem[16'h0001] = 8'h20;
    reset_release();
    wait_valid("wrap", 14);
    n_cmp++;
    if ({o_op, o_lo, o_hi, o_len, o_pc} !== {8'hAD, 8'h10, 8'h20, 2'd3, 16'hFFFF}) begin
      n_mis++;
      $display("FAIL wrap_instr: op=%h lo=%h hi=%h len=%0d pc=%h required ad 10 20 3 ffff",
               o_op, o_lo, o_hi, o_len, o_pc);
    end
    instr_ready = 1'b1;
    run_cycle();
    instr_ready = 1'b0;
    run_cycle();
    n_cmp++;
    if (o_en !== 1'b1 || o_addr !== 16'h0002) begin
      n_mis++;
      $display("FAIL wrap_next: en=%b addr=%h required 1 0002", o_en, o_addr);
    end
  endtask

  task automatic test_reset_mid();
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    reset_release();
    wait_valid("rstmid", 12);
    resetn = 1'b0;
    run_cycle();
    resetn = 1'b1;
    run_cycle();
    n_cmp++;
    if ({o_valid, o_en, o_addr} !== {1'b0, 1'b1, 16'hFFFC}) begin
      n_mis++;
      $display("FAIL rstmid_restart: v=%b en=%b addr=%h required 0 1 fffc", o_valid, o_en, o_addr);
    end
    wait_valid("rstmid2", 12);
    n_cmp++;
    if ({o_op, o_lo, o_pc} !== {8'hA9, 8'h42, 16'h8000}) begin
      n_mis++;
      $display("FAIL rstmid_refetch: op=%h lo=%h pc=%h required a9 42 8000", o_op, o_lo, o_pc);
    end
  endtask

  // Transaction-level model: the expected instruction is whatever memory
  // holds at the model pc; a handshake advances by the decoded length and a
  // redirect (outside the vector phase) replaces the pc.
  task automatic test_random();
    logic [15:0] exp_pc, a1, a2;
    logic [7:0]  eop;
    logic [1:0]  elen;
    logic [41:0] got, want;
    int          delivered;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    exp_pc = {mem[16'hFFFD], mem[16'hFFFC]};
    reset_release();
    for (int c = 0; c < 3; c++) begin
      pc_load_valid = 1'b1;
      pc_load_addr  = 16'($urandom);
      run_cycle();
    end
    delivered = 0;
    for (int c = 0; c < 4000 && delivered < 200; c++) begin
      instr_ready   = ($urandom_range(0, 3) != 0);
      pc_load_valid = ($urandom_range(0, 15) == 0);
      pc_load_addr  = 16'($urandom);
      run_cycle();
      if (o_valid) begin
        a1   = exp_pc + 16'd1;
        a2   = exp_pc + 16'd2;
        eop  = mem[exp_pc];
        elen = ref_len(eop);
        want = {exp_pc, eop, (elen >= 2'd2) ? mem[a1] : 8'h00,
                (elen == 2'd3) ? mem[a2] : 8'h00, elen};
        got  = {o_pc, o_op, o_lo, o_hi, o_len};
        n_cmp++;
        if (got !== want || o_en !== 1'b0) begin
          n_mis++;
          $display("FAIL rand_instr: got pc/op/lo/hi/len=%h en=%b required %h en=0",
                   got, o_en, want);
        end
        if (instr_ready) begin
          exp_pc = exp_pc + 16'(elen);
          delivered++;
        end
      end
      if (pc_load_valid) exp_pc = pc_load_addr;
    end
    pc_load_valid = 1'b0;
    instr_ready   = 1'b0;
    n_cmp++;
    if (delivered < 200) begin
      n_mis++;
      $display("FAIL rand_progress: delivered %0d instructions, required 200", delivered);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    instr_ready   = 1'b0;
    pc_load_valid = 1'b0;
    pc_load_addr  = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_first_fetch();
    test_three_byte();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
